avmm_burst_arbiter: RTL and testbench
=====================================

AVMM_BURST_ARBITER -- requirements
Module: avmm_burst_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, EMIF word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 28, word address width.
REQ-003 SHALL have parameter BURST_WIDTH, default 7, burstcount width; legal burstcount is 1..64.
REQ-004 SHALL have parameter TAG_DEPTH, default 16, number of outstanding read commands, power of two.
REQ-005 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous, active-high.
REQ-007 SHALL have port m_address, input, 2x ADDR_WIDTH, per-master address (index 0/1).
REQ-008 SHALL have port m_read / m_write, input, 2x1, per-master commands.
REQ-009 SHALL have port m_writedata, input, 2x DATA_WIDTH, per-master write data.
REQ-010 SHALL have port m_burstcount, input, 2x BURST_WIDTH, per-master burst length.
REQ-011 SHALL have port m_waitrequest, output, 2x1, per-master stall.
REQ-012 SHALL have port m_readdata, output, DATA_WIDTH, shared return data.
REQ-013 SHALL have port m_readdatavalid, output, 2x1, per-master return valid.
REQ-014 SHALL have ports s_address, s_read, s_write, s_writedata, s_burstcount, outputs, widths as above, EMIF command.
REQ-015 SHALL have ports s_readdata (DATA_WIDTH), s_readdatavalid (1), s_waitrequest (1), inputs, EMIF response and stall.

Function
REQ-016 SHALL run FSM IDLE, GRANT, WBURST; IDLE->GRANT when a master requests (read or write), selecting the winner combinationally in the same cycle.
REQ-017 SHALL arbitrate round-robin: on simultaneous requests the master not granted last wins; after reset master 0 has priority.
REQ-018 SHALL pass the granted master's command combinationally to s_*; m_waitrequest[g] = s_waitrequest, and the other master's m_waitrequest = 1.
REQ-019 SHALL treat a read as accepted when s_read && !s_waitrequest; then push {master id, burstcount} into the tag FIFO and return to IDLE.
REQ-020 SHALL treat a write as accepted per beat when s_write && !s_waitrequest. After the first beat of a burst >1, it enters WBURST and holds the grant until beat number burstcount (counted from the first-beat value) is accepted, then returns to IDLE.
REQ-021 SHALL hold m_waitrequest=1 for read requests while the tag FIFO is full; a write from the other master may still be granted.
REQ-022 SHALL route each s_readdatavalid beat to m_readdatavalid[head id] in the same cycle, count beats, and pop the tag when the count reaches head burstcount.
REQ-023 SHALL allow tag push and pop in the same cycle with occupancy unchanged; a pointer wrap at TAG_DEPTH is seamless.
REQ-024 SHALL ignore s_readdatavalid while the tag FIFO is empty (protocol error, no output).
REQ-025 SHALL drive all s_* outputs to 0 when no master is granted.

Reset
REQ-026 SHALL on reset return FSM to IDLE, clear tag FIFO, beat counters and round-robin pointer (master 0 priority), force m_readdatavalid=0 and s_read=s_write=0 the same cycle, and set m_waitrequest=2'b11 during reset.
REQ-027 SHALL on reset mid-burst abandon the burst and any outstanding read tags without completing them.

Configuration
REQ-028 SHALL with macro AVMM_ARB_STATS_EN defined add outputs grant_cnt (2x32) and stall_cnt (2x32), counting accepted commands and cycles with m_waitrequest=1 while requesting, cleared by reset, saturating at all-ones.
REQ-029 SHALL without AVMM_ARB_STATS_EN have no such ports or counters and be otherwise identical.

Structure
REQ-030 SHALL place the tag struct {id, burstcount} typedef, the FSM state enum and the default constants in package avmm_arb_pkg.
REQ-031 SHALL implement the tag FIFO as sub-module avmm_arb_tag_fifo (push, pop, full, empty, head).

Verification
REQ-032 SHALL cover: both masters read with burstcount 4 in the same cycle -> master 0 granted first, then master 1; 8 beats return, first 4 on m_readdatavalid[0], next 4 on [1].
REQ-033 SHALL cover: master 0 write burst of 8 with s_waitrequest high on beat 3 for 2 cycles, master 1 reading meanwhile -> master 1 stalled until beat 8 is accepted, then granted.
REQ-034 SHALL cover: 16 outstanding reads without responses -> 17th read held with waitrequest=1; one full burst returns -> read accepted the next cycle.
REQ-035 SHALL cover: a burst pop and a new push in the same cycle with the FIFO full -> occupancy stays 16 and no tag is lost.
REQ-036 SHALL cover: reset asserted mid-WBURST with 3 tags outstanding -> next cycle IDLE, FIFO empty, a subsequent master 1 request granted only if master 0 is not requesting.
REQ-037 SHALL cover with AVMM_ARB_STATS_EN: 5 reads from master 1 with 3 stall cycles -> grant_cnt[1]=5, stall_cnt[1]=3.

Source files
------------

// File: rtl/avmm_arb_pkg.sv
// Shared types and default constants for the two-master Avalon-MM burst arbiter.
package avmm_arb_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 512;
    localparam int unsigned DEF_ADDR_WIDTH  = 28;
    localparam int unsigned DEF_BURST_WIDTH = 7;
    localparam int unsigned DEF_TAG_DEPTH   = 16;

    // Tags always hold the full legal burst range (1..64), whatever BURST_WIDTH is.
    localparam int unsigned TAG_BC_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WBURST
    } arb_state_e;

    typedef struct packed {
        logic                    id;
        logic [TAG_BC_WIDTH-1:0] burstcount;
    } tag_t;

endpackage

// File: rtl/avmm_arb_tag_fifo.sv
// Outstanding-read tag FIFO: one {master id, burstcount} entry per accepted read command.
module avmm_arb_tag_fifo
    import avmm_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_TAG_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output logic full,
    output logic empty,
    output tag_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    tag_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == (PTR_W + 1)'(DEPTH));
    assign head   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/avmm_burst_arbiter.sv
// Two-master round-robin Avalon-MM burst arbiter in front of one EMIF port.
// Define AVMM_ARB_STATS_EN to add per-master grant_cnt / stall_cnt statistics outputs.
module avmm_burst_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int unsigned TAG_DEPTH   = DEF_TAG_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0][ADDR_WIDTH-1:0]  m_address,
    input  logic [1:0]                  m_read,
    input  logic [1:0]                  m_write,
    input  logic [1:0][DATA_WIDTH-1:0]  m_writedata,
    input  logic [1:0][BURST_WIDTH-1:0] m_burstcount,
    output logic [1:0]                  m_waitrequest,
    output logic [DATA_WIDTH-1:0]       m_readdata,
    output logic [1:0]                  m_readdatavalid,
    output logic [ADDR_WIDTH-1:0]       s_address,
    output logic                        s_read,
    output logic                        s_write,
    output logic [DATA_WIDTH-1:0]       s_writedata,
    output logic [BURST_WIDTH-1:0]      s_burstcount,
    input  logic [DATA_WIDTH-1:0]       s_readdata,
    input  logic                        s_readdatavalid,
    input  logic                        s_waitrequest
`ifdef AVMM_ARB_STATS_EN
    ,
    output logic [1:0][31:0]            grant_cnt,
    output logic [1:0][31:0]            stall_cnt
`endif
);

    localparam logic [BURST_WIDTH-1:0]  BC_ONE  = BURST_WIDTH'(1);
    localparam logic [TAG_BC_WIDTH-1:0] TBC_ONE = TAG_BC_WIDTH'(1);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic                    r_gnt;
    logic                    r_prio;
    logic [BURST_WIDTH-1:0]  r_wbeat;
    logic [BURST_WIDTH-1:0]  r_wlen;
    logic [TAG_BC_WIDTH-1:0] r_rbeat;

    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_rvalid;
    logic       w_read_ok;
    tag_t       w_head;
    tag_t       w_push_tag;
    logic [1:0] w_req;
    logic       w_any;
    logic       w_win;
    logic       w_gnt;
    logic       w_active;
    logic       w_racc;
    logic       w_wacc;

    // Read return path; beats arriving with no outstanding tag are dropped.
    assign w_rvalid   = s_readdatavalid && !w_empty && !reset;
    assign w_pop      = w_rvalid && ((r_rbeat + TBC_ONE) == w_head.burstcount);
    assign m_readdata = s_readdata;

    always_comb begin
        m_readdatavalid = 2'b00;
        if (w_rvalid) begin
            m_readdatavalid[w_head.id] = 1'b1;
        end
    end

    // A read is only eligible while a tag slot is free (or frees this cycle).
    assign w_read_ok = !w_full || w_pop;
    assign w_req     = (m_read & {2{w_read_ok}}) | m_write;
    assign w_any     = |w_req;
    assign w_win     = (&w_req) ? r_prio : w_req[1];
    assign w_gnt     = (r_state == IDLE) ? w_win : r_gnt;
    assign w_active  = !reset && ((r_state != IDLE) || w_any);

    always_comb begin
        s_address     = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_writedata   = '0;
        s_burstcount  = '0;
        m_waitrequest = 2'b11;
        if (w_active) begin
            s_address    = m_address[w_gnt];
            s_read       = m_read[w_gnt] && w_read_ok && (r_state != WBURST);
            s_write      = m_write[w_gnt];
            s_writedata  = m_writedata[w_gnt];
            s_burstcount = m_burstcount[w_gnt];
            m_waitrequest[w_gnt] = s_waitrequest || !(s_read || s_write);
        end
    end

    assign w_racc = s_read && !s_waitrequest;
    assign w_wacc = s_write && !s_waitrequest;

    assign w_push_tag.id         = w_gnt;
    assign w_push_tag.burstcount = TAG_BC_WIDTH'(m_burstcount[w_gnt]);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, GRANT: begin
                if (w_active) begin
                    if (w_racc) begin
                        w_state_nxt = IDLE;
                    end else if (w_wacc) begin
                        w_state_nxt = (m_burstcount[w_gnt] > BC_ONE) ? WBURST : IDLE;
                    end else begin
                        w_state_nxt = GRANT;
                    end
                end
            end
            WBURST: begin
                if (w_wacc && ((r_wbeat + BC_ONE) == r_wlen)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_prio  <= 1'b0;
            r_wbeat <= '0;
            r_wlen  <= '0;
            r_rbeat <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_any) begin
                r_gnt  <= w_win;
                r_prio <= ~w_win;
            end
            if (w_wacc) begin
                if (r_state == WBURST) begin
                    r_wbeat <= r_wbeat + BC_ONE;
                end else begin
                    r_wbeat <= BC_ONE;
                    r_wlen  <= m_burstcount[w_gnt];
                end
            end
            if (w_pop) begin
                r_rbeat <= '0;
            end else if (w_rvalid) begin
                r_rbeat <= r_rbeat + TBC_ONE;
            end
        end
    end

    avmm_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_racc),
        .push_tag (w_push_tag),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head)
    );

`ifdef AVMM_ARB_STATS_EN
    logic [1:0][31:0] r_grant_cnt;
    logic [1:0][31:0] r_stall_cnt;
    logic             w_start;

    // A write burst counts once, on its first accepted beat.
    assign w_start = w_racc || (w_wacc && (r_state != WBURST));

    for (genvar g = 0; g < 2; g++) begin : g_stats
        always_ff @(posedge clk) begin
            if (reset) begin
                r_grant_cnt[g] <= '0;
                r_stall_cnt[g] <= '0;
            end else begin
                if (w_start && (w_gnt == 1'(g)) && (r_grant_cnt[g] != '1)) begin
                    r_grant_cnt[g] <= r_grant_cnt[g] + 32'd1;
                end
                if ((m_read[g] || m_write[g]) && m_waitrequest[g] && (r_stall_cnt[g] != '1)) begin
                    r_stall_cnt[g] <= r_stall_cnt[g] + 32'd1;
                end
            end
        end
    end

    assign grant_cnt = r_grant_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_avmm_burst_arbiter.sv
// Directed bench for avmm_burst_arbiter: arbitration, write bursts, tag FIFO limits, reset.
module tb_avmm_burst_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 28;
    localparam int unsigned BW = 7;
    localparam int unsigned TD = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [1:0][AW-1:0]  m_address;
    logic [1:0]          m_read;
    logic [1:0]          m_write;
    logic [1:0][DW-1:0]  m_writedata;
    logic [1:0][BW-1:0]  m_burstcount;
    logic [1:0]          m_waitrequest;
    logic [DW-1:0]       m_readdata;
    logic [1:0]          m_readdatavalid;
    logic [AW-1:0]       s_address;
    logic                s_read;
    logic                s_write;
    logic [DW-1:0]       s_writedata;
    logic [BW-1:0]       s_burstcount;
    logic [DW-1:0]       s_readdata;
    logic                s_readdatavalid;
    logic                s_waitrequest;
`ifdef AVMM_ARB_STATS_EN
    logic [1:0][31:0]    grant_cnt;
    logic [1:0][31:0]    stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avmm_burst_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BURST_WIDTH (BW),
        .TAG_DEPTH   (TD)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_burstcount    (m_burstcount),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_burstcount    (s_burstcount),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .s_waitrequest   (s_waitrequest)
`ifdef AVMM_ARB_STATS_EN
        ,
        .grant_cnt       (grant_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic m, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                              input string tag);
        m_read[m]       = 1'b1;
        m_address[m]    = a;
        m_burstcount[m] = bc;
        @(negedge clk);
        check_eq(tag, 64'(m_waitrequest), m ? 64'h1 : 64'h2);
        step();
        m_read[m] = 1'b0;
    endtask

    task automatic ret_beats(input int n, input logic [1:0] exp_v, input string tag);
        for (int b = 0; b < n; b++) begin
            s_readdatavalid = 1'b1;
            s_readdata      = DW'(64'hD000 + 64'(b));
            @(negedge clk);
            check_eq(tag, 64'(m_readdatavalid), 64'(exp_v));
            step();
        end
        s_readdatavalid = 1'b0;
    endtask

    initial begin
        int beat;
        reset           = 1'b1;
        m_address       = '0;
        m_writedata     = '0;
        m_burstcount    = '0;
        m_read          = 2'b11;
        m_write         = 2'b00;
        s_readdata      = '0;
        s_readdatavalid = 1'b1;
        s_waitrequest   = 1'b0;

        // Reset: everything held off even with requests and return data present.
        step();
        @(negedge clk);
        check_eq("rst_waitreq", 64'(m_waitrequest), 64'h3);
        check_eq("rst_s_read", 64'(s_read), 64'h0);
        check_eq("rst_rdvalid", 64'(m_readdatavalid), 64'h0);
        step();
        reset           = 1'b0;
        m_read          = 2'b00;
        s_readdatavalid = 1'b0;

        // Simultaneous burst-4 reads: master 0 first, then master 1, returns routed in order.
        m_address[0]    = 28'h100;
        m_address[1]    = 28'h200;
        m_burstcount[0] = 7'd4;
        m_burstcount[1] = 7'd4;
        m_read          = 2'b11;
        @(negedge clk);
        check_eq("a_gnt0_waitreq", 64'(m_waitrequest), 64'h2);
        check_eq("a_gnt0_addr", 64'(s_address), 64'h100);
        check_eq("a_gnt0_bc", 64'(s_burstcount), 64'h4);
        step();
        m_read[0] = 1'b0;
        @(negedge clk);
        check_eq("a_gnt1_waitreq", 64'(m_waitrequest), 64'h1);
        check_eq("a_gnt1_addr", 64'(s_address), 64'h200);
        step();
        m_read[1] = 1'b0;
        for (int b = 0; b < 8; b++) begin
            s_readdatavalid = 1'b1;
            s_readdata      = DW'(64'hA0 + 64'(b));
            @(negedge clk);
            check_eq("a_rdvalid", 64'(m_readdatavalid), (b < 4) ? 64'h1 : 64'h2);
            check_eq("a_rdata", 64'(m_readdata), 64'hA0 + 64'(b));
            step();
        end
        s_readdatavalid = 1'b1;
        @(negedge clk);
        check_eq("a_empty_rdvalid", 64'(m_readdatavalid), 64'h0);
        step();
        s_readdatavalid = 1'b0;

        // Write burst 8 from master 0 with 2 stall cycles on beat 3; master 1 read waits.
        m_address[0]    = 28'h300;
        m_burstcount[0] = 7'd8;
        m_write[0]      = 1'b1;
        m_address[1]    = 28'h400;
        m_burstcount[1] = 7'd2;
        m_read[1]       = 1'b1;
        beat            = 0;
        for (int c = 0; c < 10; c++) begin
            s_waitrequest  = (c == 2) || (c == 3);
            m_writedata[0] = DW'(64'hB0 + 64'(beat));
            @(negedge clk);
            check_eq("b_waitreq", 64'(m_waitrequest), ((c == 2) || (c == 3)) ? 64'h3 : 64'h2);
            check_eq("b_wdata", 64'(s_writedata), 64'hB0 + 64'(beat));
            step();
            if (!((c == 2) || (c == 3))) begin
                beat++;
            end
        end
        s_waitrequest = 1'b0;
        m_write[0]    = 1'b0;
        @(negedge clk);
        check_eq("b_gnt1_waitreq", 64'(m_waitrequest), 64'h1);
        check_eq("b_gnt1_addr", 64'(s_address), 64'h400);
        step();
        m_read[1] = 1'b0;
        ret_beats(2, 2'b10, "b_rdvalid1");

        // Fill 16 tags; 17th read held until a burst completes, swapping in the same cycle.
        for (int i = 0; i < 16; i++) begin
            issue_read(1'(i % 2), AW'(28'h1000 + i), 7'd2, "c_fill");
        end
        m_read[0]       = 1'b1;
        m_address[0]    = 28'h2000;
        m_burstcount[0] = 7'd2;
        @(negedge clk);
        check_eq("c_full_hold", 64'(m_waitrequest), 64'h3);
        step();
        s_readdatavalid = 1'b1;
        @(negedge clk);
        check_eq("c_beat1_rdvalid", 64'(m_readdatavalid), 64'h1);
        check_eq("c_beat1_hold", 64'(m_waitrequest), 64'h3);
        step();
        @(negedge clk);
        check_eq("c_beat2_rdvalid", 64'(m_readdatavalid), 64'h1);
        check_eq("c_swap_waitreq", 64'(m_waitrequest), 64'h2);
        check_eq("c_swap_sread", 64'(s_read), 64'h1);
        step();
        s_readdatavalid = 1'b0;
        m_read[0]       = 1'b0;
        m_read[1]       = 1'b1;
        m_address[1]    = 28'h2100;
        @(negedge clk);
        check_eq("c_still_full", 64'(m_waitrequest), 64'h3);
        step();
        m_read[1] = 1'b0;
        for (int i = 1; i < 16; i++) begin
            ret_beats(2, (i % 2 == 1) ? 2'b10 : 2'b01, "c_drain");
        end
        ret_beats(2, 2'b01, "c_drain_new");
        s_readdatavalid = 1'b1;
        @(negedge clk);
        check_eq("c_empty_rdvalid", 64'(m_readdatavalid), 64'h0);
        step();
        s_readdatavalid = 1'b0;

        // Reset in the middle of a write burst with 3 master-1 tags outstanding.
        for (int i = 0; i < 3; i++) begin
            issue_read(1'b1, AW'(28'h500 + i), 7'd1, "d_rd");
        end
        m_write[0]      = 1'b1;
        m_address[0]    = 28'h600;
        m_burstcount[0] = 7'd8;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("d_wbeat", 64'(m_waitrequest), 64'h2);
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        check_eq("d_rst_waitreq", 64'(m_waitrequest), 64'h3);
        check_eq("d_rst_swrite", 64'(s_write), 64'h0);
        step();
        reset           = 1'b0;
        m_write         = 2'b00;
        s_readdatavalid = 1'b1;
        @(negedge clk);
        check_eq("d_fifo_empty", 64'(m_readdatavalid), 64'h0);
        step();
        s_readdatavalid = 1'b0;
        m_address[0]    = 28'h700;
        m_address[1]    = 28'h800;
        m_burstcount[0] = 7'd1;
        m_burstcount[1] = 7'd1;
        m_read          = 2'b11;
        @(negedge clk);
        check_eq("d_prio0_waitreq", 64'(m_waitrequest), 64'h2);
        check_eq("d_prio0_addr", 64'(s_address), 64'h700);
        step();
        m_read[0] = 1'b0;
        @(negedge clk);
        check_eq("d_gnt1_waitreq", 64'(m_waitrequest), 64'h1);
        step();
        m_read[1] = 1'b0;
        ret_beats(1, 2'b01, "d_new_tag0");
        ret_beats(1, 2'b10, "d_new_tag1");

`ifdef AVMM_ARB_STATS_EN
        // 5 accepted reads from master 1 across 8 requesting cycles, 3 of them stalled.
        reset = 1'b1;
        step();
        reset           = 1'b0;
        m_read[1]       = 1'b1;
        m_address[1]    = 28'h900;
        m_burstcount[1] = 7'd1;
        for (int c = 0; c < 8; c++) begin
            s_waitrequest = (c == 1) || (c == 3) || (c == 4);
            step();
        end
        m_read[1]     = 1'b0;
        s_waitrequest = 1'b0;
        @(negedge clk);
        check_eq("e_grant_cnt1", 64'(grant_cnt[1]), 64'd5);
        check_eq("e_stall_cnt1", 64'(stall_cnt[1]), 64'd3);
        check_eq("e_grant_cnt0", 64'(grant_cnt[0]), 64'd0);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
